// File: rtl/gol_pkg.sv
// Shared sizes, FSM state encoding and cell addressing for the Game of Life engine.
// Pure declarations; no timing or flow control of its own.
package gol_pkg;

   localparam int GOL_COLS  = 64;
   localparam int GOL_ROWS  = 48;
   localparam int GOL_CELLS = GOL_COLS * GOL_ROWS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      COMMIT  = 2'd2
   } gol_state_t;

   function automatic int cell_idx(input int row, input int col);
      return row * GOL_COLS + col;
   endfunction

endpackage

// File: rtl/gol_row_next.sv
// Next-state of one row from the rows above, at and below it; purely combinational.
// Zero latency, no flow control; column edges either read dead or wrap around.
module gol_row_next
   import gol_pkg::*;
#(
   parameter int COLS = GOL_COLS,
   parameter bit WRAP = 1'b0
) (
   input  logic [COLS-1:0] above,
   input  logic [COLS-1:0] cur,
   input  logic [COLS-1:0] below,
   output logic [COLS-1:0] next
);

   logic [3:0] n;

   function automatic logic [3:0] count_at(input logic [COLS-1:0] a,
                                           input logic [COLS-1:0] m,
                                           input logic [COLS-1:0] b,
                                           input int c);
      int   lc;
      int   rc;
      logic lv;
      logic rv;
      lc = (c == 0) ? COLS - 1 : c - 1;
      rc = (c == COLS - 1) ? 0 : c + 1;
      lv = WRAP || (c != 0);
      rv = WRAP || (c != COLS - 1);
      return 4'(a[lc] & lv) + 4'(a[c]) + 4'(a[rc] & rv)
           + 4'(m[lc] & lv)             + 4'(m[rc] & rv)
           + 4'(b[lc] & lv) + 4'(b[c]) + 4'(b[rc] & rv);
   endfunction

   always_comb begin
      next = '0;
      n    = '0;
      for (int c = 0; c < COLS; c++) begin
         n       = count_at(above, cur, below, c);
         next[c] = (cur[c] & ((n == 4'd2) | (n == 4'd3))) | (!cur[c] & (n == 4'd3));
      end
   end

endmodule

// File: rtl/gol_gen_engine.sv
// Owns the committed grid; computes one row per clock into a shadow buffer, then commits it whole.
// Trigger to new cells is 49 edges; commands arriving while busy are dropped, never queued.
module gol_gen_engine
   import gol_pkg::*;
#(
   parameter int COLS = GOL_COLS,
   parameter int ROWS = GOL_ROWS,
   parameter bit WRAP = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 step,
   input  logic                 gen_tick,
   input  logic                 clear,
   input  logic                 seed_we,
   input  logic [5:0]           seed_row,
   input  logic [COLS-1:0]      seed_data,
   output logic [0:ROWS*COLS-1] cells,
   output logic                 busy,
   output logic                 gen_done,
   output logic [15:0]          gen_count
);

   localparam int         CELLS    = ROWS * COLS;
   localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

   gol_state_t       state_q, state_d;
   logic [5:0]       row_q;
   logic [CELLS-1:0] grid_q;
   logic [CELLS-1:0] shadow_q;
   logic [15:0]      count_q;
   logic             done_q;
   logic [COLS-1:0]  above, cur, below, next_row;
   logic             trigger, do_clear, do_seed, do_start;

   function automatic logic [COLS-1:0] grid_row(input logic [CELLS-1:0] g, input int r);
      return g[r*COLS +: COLS];
   endfunction

   // Neighbour rows always come from the committed grid, never the shadow.
   always_comb begin
      cur   = grid_row(grid_q, int'(row_q));
      above = '0;
      below = '0;
      if (row_q != 6'd0)
         above = grid_row(grid_q, int'(row_q) - 1);
      else if (WRAP)
         above = grid_row(grid_q, ROWS - 1);
      if (row_q != LAST_ROW)
         below = grid_row(grid_q, int'(row_q) + 1);
      else if (WRAP)
         below = grid_row(grid_q, 0);
   end

   gol_row_next #(.COLS(COLS), .WRAP(WRAP)) u_row_next (
      .above (above),
      .cur   (cur),
      .below (below),
      .next  (next_row)
   );

   always_comb begin
      state_d  = state_q;
      trigger  = step | (run & gen_tick);
      do_clear = 1'b0;
      do_seed  = 1'b0;
      do_start = 1'b0;
      case (state_q)
         IDLE: begin
            // A trigger alongside clear or seed_we is dropped, even for an out-of-range seed row.
            if (clear)
               do_clear = 1'b1;
            else if (seed_we)
               do_seed = (seed_row <= LAST_ROW);
            else if (trigger) begin
               do_start = 1'b1;
               state_d  = COMPUTE;
            end
         end
         COMPUTE: if (row_q == LAST_ROW) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grid_q   <= '0;
         shadow_q <= '0;
         count_q  <= '0;
         row_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == COMMIT);
         if (do_clear) begin
            grid_q  <= '0;
            count_q <= '0;
         end else if (do_seed) begin
            grid_q[int'(seed_row)*COLS +: COLS] <= seed_data;
         end else if (state_q == COMMIT) begin
            grid_q  <= shadow_q;
            count_q <= count_q + 16'd1;
         end
         if (do_start)
            row_q <= '0;
         else if (state_q == COMPUTE) begin
            shadow_q[int'(row_q)*COLS +: COLS] <= next_row;
            if (row_q != LAST_ROW)
               row_q <= row_q + 6'd1;
         end
      end
   end

   always_comb begin
      cells = '0;
      for (int i = 0; i < CELLS; i++)
         cells[i] = grid_q[i];
   end

   assign busy      = (state_q != IDLE);
   assign gen_done  = done_q;
   assign gen_count = count_q;

endmodule

// File: tb/tb_gol_gen_engine.sv
// Directed bench: blinker, still life, edge rule (both WRAP settings), lockout, priority, reset, count wrap.
module tb_gol_gen_engine;
   import gol_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset, run, step, gen_tick, clear, seed_we;
   logic [5:0]           seed_row;
   logic [GOL_COLS-1:0]  seed_data;
   logic [0:GOL_CELLS-1] cells0, cells1;
   logic                 busy0, busy1, done0, done1;
   logic [15:0]          cnt0, cnt1;

   logic [0:GOL_CELLS-1] exp_g;
   logic [0:GOL_CELLS-1] zero_g;
   int checks = 0;
   int errors = 0;
   int busy_n, done_n, done_at;

   always #5 clk = ~clk;

   gol_gen_engine #(.WRAP(1'b0)) dut0 (
      .clk(clk), .reset(reset), .run(run), .step(step), .gen_tick(gen_tick),
      .clear(clear), .seed_we(seed_we), .seed_row(seed_row), .seed_data(seed_data),
      .cells(cells0), .busy(busy0), .gen_done(done0), .gen_count(cnt0)
   );

   gol_gen_engine #(.WRAP(1'b1)) dut1 (
      .clk(clk), .reset(reset), .run(run), .step(step), .gen_tick(gen_tick),
      .clear(clear), .seed_we(seed_we), .seed_row(seed_row), .seed_data(seed_data),
      .cells(cells1), .busy(busy1), .gen_done(done1), .gen_count(cnt1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic chk_grid(input string tag, input logic [0:GOL_CELLS-1] obs,
                           input logic [0:GOL_CELLS-1] expv);
      int first;
      checks++;
      assert (obs === expv) else begin
         errors++;
         first = -1;
         for (int i = GOL_CELLS - 1; i >= 0; i--)
            if (obs[i] !== expv[i]) first = i;
         $error("FAIL %s: got %0d live cells expected %0d, first difference at index %0d",
                tag, $countones(obs), $countones(expv), first);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic seed(input int r, input logic [GOL_COLS-1:0] d);
      seed_we = 1'b1; seed_row = 6'(r); seed_data = d;
      cyc(1);
      seed_we = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
   endtask

   task automatic exp_row(input int r, input logic [GOL_COLS-1:0] d);
      for (int c = 0; c < GOL_COLS; c++) exp_g[cell_idx(r, c)] = d[c];
   endtask

   // One generation: trigger, then observe 60 samples starting one edge after the trigger.
   task automatic run_gen(input string tag, input bit use_tick);
      if (use_tick) gen_tick = 1'b1; else step = 1'b1;
      cyc(1);
      gen_tick = 1'b0; step = 1'b0;
      busy_n = 0; done_n = 0; done_at = -1;
      for (int i = 0; i < 60; i++) begin
         busy_n += int'(busy0);
         if (done0) begin
            done_n++;
            if (done_at < 0) done_at = i;
         end
         cyc(1);
      end
      chk({tag, " busy cycles"}, 64'(busy_n), 64'd49);
      chk({tag, " gen_done pulses"}, 64'(done_n), 64'd1);
      chk({tag, " gen_done timing"}, 64'(done_at), 64'd49);
   endtask

   task automatic seed_blinker();
      seed(10, 64'd1 << 20);
      seed(11, 64'd1 << 20);
      seed(12, 64'd1 << 20);
   endtask

   initial begin
      zero_g = '0;
      reset = 1'b1; run = 1'b0; step = 1'b0; gen_tick = 1'b0; clear = 1'b0;
      seed_we = 1'b0; seed_row = '0; seed_data = '0;
      cyc(2);
      chk_grid("reset cells", cells0, zero_g);
      chk("reset busy", 64'(busy0), 64'd0);
      chk("reset gen_done", 64'(done0), 64'd0);
      chk("reset gen_count", 64'(cnt0), 64'd0);
      reset = 1'b0;
      cyc(1);

      // Blinker oscillates vertical -> horizontal -> vertical
      seed_blinker();
      run_gen("blinker1", 1'b0);
      exp_g = '0;
      exp_row(11, 64'h7 << 19);
      chk_grid("blinker horizontal", cells0, exp_g);
      chk("blinker count1", 64'(cnt0), 64'd1);
      run_gen("blinker2", 1'b0);
      exp_g = '0;
      for (int r = 10; r <= 12; r++) exp_row(r, 64'd1 << 20);
      chk_grid("blinker vertical", cells0, exp_g);
      chk("blinker count2", 64'(cnt0), 64'd2);

      // Still life driven by gen_tick while running
      do_clear();
      chk("clear zeroes count", 64'(cnt0), 64'd0);
      seed(0, 64'h3);
      seed(1, 64'h3);
      gen_tick = 1'b1;
      cyc(1);
      gen_tick = 1'b0;
      chk("tick without run", 64'(busy0), 64'd0);
      run = 1'b1;
      for (int k = 0; k < 3; k++) begin
         run_gen("block tick", 1'b1);
         cyc(40);
      end
      run = 1'b0;
      exp_g = '0;
      exp_row(0, 64'h3);
      exp_row(1, 64'h3);
      chk_grid("block unchanged", cells0, exp_g);
      chk("block count", 64'(cnt0), 64'd3);

      // Corner cells: dead edges vs toroidal wrap
      do_clear();
      seed(0, 64'h8000_0000_0000_0001);
      seed(47, 64'h1);
      run_gen("edge", 1'b0);
      chk_grid("edge wrap0", cells0, zero_g);
      exp_g = '0;
      exp_g[0] = 1'b1; exp_g[63] = 1'b1; exp_g[3008] = 1'b1; exp_g[3071] = 1'b1;
      chk_grid("edge wrap1", cells1, exp_g);
      chk("edge wrap1 count", 64'(cnt1), 64'd1);

      // Everything pulsed while busy is ignored
      do_clear();
      seed_blinker();
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      busy_n = 0; done_n = 0;
      for (int i = 0; i < 200; i++) begin
         busy_n += int'(busy0);
         done_n += int'(done0);
         if (i == 9) begin
            run = 1'b1; step = 1'b1; gen_tick = 1'b1; clear = 1'b1;
            seed_we = 1'b1; seed_row = 6'd5; seed_data = '1;
         end
         cyc(1);
         if (i == 9) begin
            run = 1'b0; step = 1'b0; gen_tick = 1'b0; clear = 1'b0; seed_we = 1'b0;
         end
      end
      chk("lockout busy cycles", 64'(busy_n), 64'd49);
      chk("lockout gen_done pulses", 64'(done_n), 64'd1);
      chk("lockout count", 64'(cnt0), 64'd1);
      chk("lockout row5", 64'(cells0[cell_idx(5, 0) +: GOL_COLS]), 64'd0);
      exp_g = '0;
      exp_row(11, 64'h7 << 19);
      chk_grid("lockout grid", cells0, exp_g);

      // IDLE priority: seed beats step, clear beats seed
      seed_we = 1'b1; seed_row = 6'd30; seed_data = 64'hF0F0; step = 1'b1;
      cyc(1);
      seed_we = 1'b0; step = 1'b0;
      busy_n = 0;
      for (int i = 0; i < 60; i++) begin
         busy_n += int'(busy0);
         cyc(1);
      end
      chk("seed+step no busy", 64'(busy_n), 64'd0);
      chk("seed+step count", 64'(cnt0), 64'd1);
      exp_row(30, 64'hF0F0);
      chk_grid("seed+step grid", cells0, exp_g);
      seed(50, '1);
      chk_grid("out-of-range seed ignored", cells0, exp_g);
      clear = 1'b1; seed_we = 1'b1; seed_row = 6'd7; seed_data = '1;
      cyc(1);
      clear = 1'b0; seed_we = 1'b0;
      chk_grid("clear+seed grid", cells0, zero_g);
      chk("clear+seed count", 64'(cnt0), 64'd0);

      // Asynchronous reset in the middle of COMPUTE
      seed_blinker();
      run_gen("pre-reset", 1'b0);
      chk("pre-reset count", 64'(cnt0), 64'd1);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(20);
      #2 reset = 1'b1;
      #1;
      chk_grid("midop reset cells", cells0, zero_g);
      chk("midop reset busy", 64'(busy0), 64'd0);
      chk("midop reset count", 64'(cnt0), 64'd0);
      #2 reset = 1'b0;
      cyc(1);
      busy_n = 0; done_n = 0;
      for (int i = 0; i < 60; i++) begin
         busy_n += int'(busy0);
         done_n += int'(done0);
         cyc(1);
      end
      chk("post-reset busy", 64'(busy_n), 64'd0);
      chk("post-reset gen_done", 64'(done_n), 64'd0);

      // gen_count wraps silently
      force dut0.count_q = 16'hFFFF;
      cyc(1);
      release dut0.count_q;
      cyc(1);
      chk("preload count", 64'(cnt0), 64'd65535);
      run_gen("wrap", 1'b0);
      chk("count wraps", 64'(cnt0), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
